// File: rtl/convz_drain.sv
// Captures convolution-core Z writes into a local buffer and streams them out in address order on done.
// Optional macro CONVZ_UNWRITTEN_ZERO_EN: unwritten addresses drain as zero.
module convz_drain #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  writeZ,
   input  logic [ADDR_WIDTH-1:0] memZ_addr,
   input  logic [DATA_WIDTH-1:0] dataZ,
   input  logic                  conv_done,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  out_last,
   output logic                  busy,
   output logic                  err_wr,
   output logic                  int_drained
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, LAST} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data;
   logic [ADDR_WIDTH-1:0] max_addr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] rd_addr_c;
   logic [ADDR_WIDTH-1:0] max_next_c;
   logic [DATA_WIDTH-1:0] beat_data_c;
   logic                  any_wr;
   logic                  prime;
   logic                  wr_en_c;
   logic                  rd_en_c;
   logic                  load_c;
   logic                  at_max_c;
`ifdef CONVZ_UNWRITTEN_ZERO_EN
   logic [DEPTH-1:0]      written;
`endif

   // rd_ptr names the entry held in rd_data; the output stage loads from it and fetches the next one
   always_comb begin
      wr_en_c     = writeZ && ((state == IDLE) || (state == CAPTURE));
      load_c      = (state == DRAIN) && !prime && (!out_valid || out_ready);
      at_max_c    = (rd_ptr == max_addr);
      max_next_c  = (memZ_addr > max_addr) ? memZ_addr : max_addr;
      rd_en_c     = 1'b0;
      rd_addr_c   = rd_ptr;
      if ((state == DRAIN) && prime) begin
         rd_en_c = 1'b1;
      end else if (load_c && !at_max_c) begin
         rd_en_c   = 1'b1;
         rd_addr_c = rd_ptr + ADDR_WIDTH'(1);
      end
`ifdef CONVZ_UNWRITTEN_ZERO_EN
      beat_data_c = written[rd_ptr] ? rd_data : '0;
`else
      beat_data_c = rd_data;
`endif
   end

   // Result buffer: no reset, one-cycle synchronous read
   always_ff @(posedge clk) begin
      if (wr_en_c) mem[memZ_addr] <= dataZ;
      if (rd_en_c) rd_data <= mem[rd_addr_c];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         max_addr    <= '0;
         rd_ptr      <= '0;
         any_wr      <= 1'b0;
         prime       <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_addr    <= '0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         err_wr      <= 1'b0;
         int_drained <= 1'b0;
`ifdef CONVZ_UNWRITTEN_ZERO_EN
         written     <= '0;
`endif
      end else begin
         int_drained <= 1'b0;
         if (writeZ && ((state == DRAIN) || (state == LAST))) err_wr <= 1'b1;
`ifdef CONVZ_UNWRITTEN_ZERO_EN
         if (wr_en_c) written[memZ_addr] <= 1'b1;
`endif
         case (state)
            IDLE: begin
               if (writeZ) begin
                  any_wr   <= 1'b1;
                  max_addr <= memZ_addr;
                  busy     <= 1'b1;
                  if (conv_done) begin
                     state  <= DRAIN;
                     rd_ptr <= '0;
                     prime  <= 1'b1;
                  end else begin
                     state  <= CAPTURE;
                  end
               end else if (conv_done && !any_wr) begin
                  int_drained <= 1'b1;
               end
            end
            CAPTURE: begin
               if (writeZ) max_addr <= max_next_c;
               if (conv_done) begin
                  state  <= DRAIN;
                  rd_ptr <= '0;
                  prime  <= 1'b1;
               end
            end
            DRAIN: begin
               if (prime) begin
                  prime <= 1'b0;
               end else if (load_c) begin
                  out_valid <= 1'b1;
                  out_data  <= beat_data_c;
                  out_addr  <= rd_ptr;
                  out_last  <= at_max_c;
                  if (at_max_c) state  <= LAST;
                  else          rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
               end
            end
            LAST: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  out_last    <= 1'b0;
                  int_drained <= 1'b1;
                  any_wr      <= 1'b0;
                  max_addr    <= '0;
                  busy        <= 1'b0;
                  state       <= IDLE;
`ifdef CONVZ_UNWRITTEN_ZERO_EN
                  written     <= '0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
